// File: rtl/spi_master_param.sv
// spi_master_param
// Parametrised full-duplex SPI master. A word accepted on the tx handshake
// is framed by one active-low chip select and shifted out on mosi. miso is
// shifted in at the same time. The received word is presented with a
// one-cycle rx_valid pulse.
// Sequence: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
// The accept cycle already drives cs_n low, which adds one cycle of cs_n
// setup ahead of the CLK_DIV-cycle SETUP phase. As a result the accept edge
// to rx_valid latency is (2*DATA_WIDTH+2)*CLK_DIV+1 cycles.
module spi_master_param #(
   parameter int DATA_WIDTH = 8,
   parameter int CLK_DIV    = 2,
   parameter int NUM_SLAVES = 2,
   parameter int LSB_FIRST  = 0,
   localparam int SEL_W     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic [SEL_W-1:0]      slave_sel,
   input  logic                  cpol,
   input  logic                  cpha,
   output logic                  rx_valid,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  busy,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic [NUM_SLAVES-1:0] cs_n
);

   localparam int BCW = $clog2(DATA_WIDTH) + 1;
   localparam int DCW = $clog2(CLK_DIV) + 1;

   localparam logic [DCW-1:0] DIV_ZERO  = {DCW{1'b0}};
   localparam logic [DCW-1:0] DIV_ONE   = DCW'(1);
   localparam logic [DCW-1:0] DIV_LAST  = DCW'(CLK_DIV - 1);
   localparam logic [DCW-1:0] DIV_SETUP = DCW'(CLK_DIV);
   localparam logic [BCW-1:0] BIT_ZERO  = {BCW{1'b0}};
   localparam logic [BCW-1:0] BIT_ONE   = BCW'(1);
   localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);
   localparam logic [NUM_SLAVES-1:0] CS_IDLE = {NUM_SLAVES{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_HOLD  = 2'd3
   } state_t;

   state_t                state_r, state_s;
   logic [DCW-1:0]        div_cnt_r, div_cnt_s;
   logic [BCW-1:0]        bit_cnt_r, bit_cnt_s;
   logic [DATA_WIDTH-1:0] tx_sh_r, tx_sh_s;
   logic [DATA_WIDTH-1:0] rx_sh_r, rx_sh_s;
   logic                  cpol_r, cpol_s;
   logic                  cpha_r, cpha_s;
   logic                  sclk_r, sclk_s;
   logic                  mosi_r, mosi_s;
   logic [NUM_SLAVES-1:0] cs_n_r, cs_n_s;
   logic                  tx_ready_r, tx_ready_s;
   logic                  rx_valid_r, rx_valid_s;
   logic [DATA_WIDTH-1:0] rx_data_r, rx_data_s;
   logic                  busy_r, busy_s;

   // Bit that goes on the wire next, for the configured bit order.
   function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
      if (LSB_FIRST != 0) first_bit = w[0];
      else                first_bit = w[DATA_WIDTH-1];
   endfunction

   // Discard the bit just transmitted.
   function automatic logic [DATA_WIDTH-1:0] tx_shift(input logic [DATA_WIDTH-1:0] w);
      if (LSB_FIRST != 0) tx_shift = {1'b0, w[DATA_WIDTH-1:1]};
      else                tx_shift = {w[DATA_WIDTH-2:0], 1'b0};
   endfunction

   // Insert a received bit so that the word is correctly ordered after DATA_WIDTH bits.
   function automatic logic [DATA_WIDTH-1:0] rx_shift(input logic [DATA_WIDTH-1:0] w,
                                                      input logic b);
      if (LSB_FIRST != 0) rx_shift = {b, w[DATA_WIDTH-1:1]};
      else                rx_shift = {w[DATA_WIDTH-2:0], b};
   endfunction

   // One-hot active-low decode. An out-of-range index leaves every select high.
   function automatic logic [NUM_SLAVES-1:0] cs_decode(input logic [SEL_W-1:0] sel);
      cs_decode = CS_IDLE;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (SEL_W'(i) == sel) cs_decode[i] = 1'b0;
         else                  cs_decode[i] = 1'b1;
      end
   endfunction

   // Next-state and next-output logic for the transfer sequencer.
   always_comb begin
      state_s    = state_r;
      div_cnt_s  = div_cnt_r;
      bit_cnt_s  = bit_cnt_r;
      tx_sh_s    = tx_sh_r;
      rx_sh_s    = rx_sh_r;
      cpol_s     = cpol_r;
      cpha_s     = cpha_r;
      sclk_s     = sclk_r;
      mosi_s     = mosi_r;
      cs_n_s     = cs_n_r;
      tx_ready_s = 1'b0;
      rx_valid_s = 1'b0;
      rx_data_s  = rx_data_r;
      busy_s     = busy_r;

      if (!enable && (state_r != ST_IDLE)) begin
         // Abort: release the bus at once and drop the partial word.
         state_s   = ST_IDLE;
         div_cnt_s = DIV_ZERO;
         cs_n_s    = CS_IDLE;
         sclk_s    = cpol_r;
         mosi_s    = 1'b0;
         busy_s    = 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               sclk_s = cpol;
               mosi_s = 1'b0;
               cs_n_s = CS_IDLE;
               busy_s = 1'b0;
               if (enable && tx_valid && tx_ready_r) begin
                  state_s   = ST_SETUP;
                  div_cnt_s = DIV_ZERO;
                  bit_cnt_s = BIT_ZERO;
                  rx_sh_s   = {DATA_WIDTH{1'b0}};
                  cpol_s    = cpol;
                  cpha_s    = cpha;
                  cs_n_s    = cs_decode(slave_sel);
                  busy_s    = 1'b1;
                  if (cpha) begin
                     mosi_s  = 1'b0;
                     tx_sh_s = tx_data;
                  end else begin
                     mosi_s  = first_bit(tx_data);
                     tx_sh_s = tx_shift(tx_data);
                  end
               end else begin
                  tx_ready_s = enable;
               end
            end
            ST_SETUP: begin
               if (div_cnt_r == DIV_SETUP) begin
                  state_s   = ST_SHIFT;
                  div_cnt_s = DIV_ZERO;
               end else begin
                  div_cnt_s = div_cnt_r + DIV_ONE;
               end
            end
            ST_SHIFT: begin
               if (div_cnt_r == DIV_LAST) begin
                  div_cnt_s = DIV_ZERO;
                  if (sclk_r == cpol_r) begin
                     // Leading edge.
                     sclk_s = ~cpol_r;
                     if (cpha_r) begin
                        mosi_s  = first_bit(tx_sh_r);
                        tx_sh_s = tx_shift(tx_sh_r);
                     end else begin
                        rx_sh_s = rx_shift(rx_sh_r, miso);
                     end
                  end else begin
                     // Trailing edge closes one bit.
                     sclk_s    = cpol_r;
                     bit_cnt_s = bit_cnt_r + BIT_ONE;
                     if (cpha_r) begin
                        rx_sh_s = rx_shift(rx_sh_r, miso);
                     end else if (bit_cnt_r != BIT_LAST) begin
                        mosi_s  = first_bit(tx_sh_r);
                        tx_sh_s = tx_shift(tx_sh_r);
                     end else begin
                        mosi_s  = mosi_r;
                     end
                     if (bit_cnt_r == BIT_LAST) state_s = ST_HOLD;
                     else                       state_s = ST_SHIFT;
                  end
               end else begin
                  div_cnt_s = div_cnt_r + DIV_ONE;
               end
            end
            ST_HOLD: begin
               sclk_s = cpol_r;
               if (div_cnt_r == DIV_LAST) begin
                  state_s    = ST_IDLE;
                  div_cnt_s  = DIV_ZERO;
                  cs_n_s     = CS_IDLE;
                  mosi_s     = 1'b0;
                  rx_data_s  = rx_sh_r;
                  rx_valid_s = 1'b1;
                  busy_s     = 1'b0;
               end else begin
                  div_cnt_s = div_cnt_r + DIV_ONE;
               end
            end
            default: begin
               state_s   = ST_IDLE;
               div_cnt_s = DIV_ZERO;
               cs_n_s    = CS_IDLE;
               busy_s    = 1'b0;
            end
         endcase
      end
   end

   // State, datapath and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r    <= ST_IDLE;
         div_cnt_r  <= DIV_ZERO;
         bit_cnt_r  <= BIT_ZERO;
         tx_sh_r    <= {DATA_WIDTH{1'b0}};
         rx_sh_r    <= {DATA_WIDTH{1'b0}};
         cpol_r     <= 1'b0;
         cpha_r     <= 1'b0;
         sclk_r     <= 1'b0;
         mosi_r     <= 1'b0;
         cs_n_r     <= CS_IDLE;
         tx_ready_r <= 1'b0;
         rx_valid_r <= 1'b0;
         rx_data_r  <= {DATA_WIDTH{1'b0}};
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         div_cnt_r  <= div_cnt_s;
         bit_cnt_r  <= bit_cnt_s;
         tx_sh_r    <= tx_sh_s;
         rx_sh_r    <= rx_sh_s;
         cpol_r     <= cpol_s;
         cpha_r     <= cpha_s;
         sclk_r     <= sclk_s;
         mosi_r     <= mosi_s;
         cs_n_r     <= cs_n_s;
         tx_ready_r <= tx_ready_s;
         rx_valid_r <= rx_valid_s;
         rx_data_r  <= rx_data_s;
         busy_r     <= busy_s;
      end
   end

   assign tx_ready = tx_ready_r;
   assign rx_valid = rx_valid_r;
   assign rx_data  = rx_data_r;
   assign busy     = busy_r;
   assign sclk     = sclk_r;
   assign mosi     = mosi_r;
   assign cs_n     = cs_n_r;

endmodule

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param
// Two instances share their inputs and are exercised one at a time:
//   dut_a: 8 bit, CLK_DIV=2, 2 slaves, MSB first
//   dut_b: 8 bit, CLK_DIV=1, 3 slaves, LSB first
// A behavioural SPI slave on the bench returns a chosen word and records the
// word it received. Otherwise miso loops back from mosi.
module tb_spi_master_param;

   logic       clk;
   logic       reset;
   logic       enable;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic [1:0] slave_sel;
   logic       cpol;
   logic       cpha;
   bit         which;
   bit         loop_v;

   logic       tx_ready_a, rx_valid_a, busy_a, sclk_a, mosi_a, miso_a;
   logic [7:0] rx_data_a;
   logic [1:0] cs_n_a;
   logic       tx_ready_b, rx_valid_b, busy_b, sclk_b, mosi_b, miso_b;
   logic [7:0] rx_data_b;
   logic [2:0] cs_n_b;

   logic       tx_ready_m, rx_valid_m, busy_m, sclk_m, mosi_m;
   logic [7:0] rx_data_m;
   logic [2:0] cs_m;
   logic       cs_act;

   logic [7:0] slv_word;
   logic [7:0] slv_got;
   logic       slv_miso;
   int         slv_k;
   int         slv_cap;

   int         cyc = 0;
   int         acc_cyc;
   int         rxv_cyc;
   int         total = 0;
   int         bad = 0;
   logic [7:0] last_rx;

   spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(2), .NUM_SLAVES(2), .LSB_FIRST(0)) dut_a (
      .clk(clk), .reset(reset), .enable(enable),
      .tx_valid(tx_valid & ~which), .tx_ready(tx_ready_a), .tx_data(tx_data),
      .slave_sel(slave_sel[0]), .cpol(cpol), .cpha(cpha),
      .rx_valid(rx_valid_a), .rx_data(rx_data_a), .busy(busy_a),
      .sclk(sclk_a), .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
   );

   spi_master_param #(.DATA_WIDTH(8), .CLK_DIV(1), .NUM_SLAVES(3), .LSB_FIRST(1)) dut_b (
      .clk(clk), .reset(reset), .enable(enable),
      .tx_valid(tx_valid & which), .tx_ready(tx_ready_b), .tx_data(tx_data),
      .slave_sel(slave_sel), .cpol(cpol), .cpha(cpha),
      .rx_valid(rx_valid_b), .rx_data(rx_data_b), .busy(busy_b),
      .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
   );

   assign tx_ready_m = which ? tx_ready_b : tx_ready_a;
   assign rx_valid_m = which ? rx_valid_b : rx_valid_a;
   assign busy_m     = which ? busy_b     : busy_a;
   assign sclk_m     = which ? sclk_b     : sclk_a;
   assign mosi_m     = which ? mosi_b     : mosi_a;
   assign rx_data_m  = which ? rx_data_b  : rx_data_a;
   assign cs_m       = which ? cs_n_b     : {1'b1, cs_n_a};
   assign cs_act     = ~(&cs_m);
   assign miso_a     = loop_v ? mosi_a : slv_miso;
   assign miso_b     = loop_v ? mosi_b : slv_miso;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // cycle counter used for latency measurement
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic word_bit(input logic [7:0] w, input int k);
      if (which) return w[k];
      return w[7-k];
   endfunction

   // slave: frame start, CPHA=0 presents its first bit immediately
   always @(posedge cs_act) begin
      slv_k   = 0;
      slv_cap = 0;
      slv_got = 8'h00;
      slv_miso = 1'b0;
      if (!cpha) begin
         slv_miso = word_bit(slv_word, 0);
         slv_k = 1;
      end
   end

   // slave: shift on SCLK edges according to the transfer mode
   always @(sclk_m) begin
      if (cs_act === 1'b1) begin
         if (((sclk_m != cpol) ? 1'b1 : 1'b0) ^ cpha) begin
            if (slv_cap < 8) begin
               if (which) slv_got[slv_cap] = mosi_m;
               else       slv_got[7-slv_cap] = mosi_m;
            end
            slv_cap = slv_cap + 1;
         end else begin
            if (slv_k < 8) slv_miso = word_bit(slv_word, slv_k);
            slv_k = slv_k + 1;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] cs_expect(input bit dut, input logic [1:0] sel);
      logic [2:0] e;
      int ns;
      ns = dut ? 3 : 2;
      e = 3'b111;
      if (int'(sel) < ns) e[sel] = 1'b0;
      return e;
   endfunction

   task automatic wait_accept(output bit ok);
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         if (tx_ready_m === 1'b1) begin
            @(posedge clk);
            #1;
            acc_cyc = cyc;
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic monitor_xfer(input logic [7:0] exp_rx, input logic [2:0] exp_cs,
                               input logic pol, input logic exp_first);
      int   tog;
      bit   seen;
      bit   cs_bad;
      bit   busy_bad;
      logic prev;
      int   lat;
      tog = 0; seen = 1'b0; cs_bad = 1'b0; busy_bad = 1'b0; prev = pol;
      lat = (2 * 8 + 2) * (which ? 1 : 2) + 1;
      for (int n = 1; n <= 300; n++) begin
         @(negedge clk);
         if (n == 1) check("first_mosi", 32'(mosi_m), 32'(exp_first));
         if (rx_valid_m === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (cs_m !== exp_cs) cs_bad = 1'b1;
         if (busy_m !== 1'b1) busy_bad = 1'b1;
         if (sclk_m !== prev) tog++;
         prev = sclk_m;
      end
      rxv_cyc = cyc;
      check("rx_valid_seen", 32'(seen), 32'd1);
      check("latency", 32'(cyc - acc_cyc), 32'(lat));
      check("rx_data", 32'(rx_data_m), 32'(exp_rx));
      check("cs_during", 32'(cs_bad), 32'd0);
      check("busy_during", 32'(busy_bad), 32'd0);
      check("sclk_toggles", 32'(tog), 32'd16);
      check("sclk_idle_after", 32'(sclk_m), 32'(pol));
      check("cs_release", 32'(cs_m), 32'h7);
      check("busy_release", 32'(busy_m), 32'd0);
      @(negedge clk);
      check("rx_pulse_one", 32'(rx_valid_m), 32'd0);
      check("cs_gap", 32'(cs_m), 32'h7);
   endtask

   task automatic xfer(input bit dut, input logic [7:0] w, input logic [1:0] sel,
                       input logic pol, input logic pha, input bit lp, input logic [7:0] sw);
      bit ok;
      which = dut; tx_data = w; slave_sel = sel; cpol = pol; cpha = pha;
      loop_v = lp; slv_word = sw;
      repeat (2) @(negedge clk);
      check("sclk_idle_before", 32'(sclk_m), 32'(pol));
      tx_valid = 1'b1;
      wait_accept(ok);
      tx_valid = 1'b0;
      check("accept", 32'(ok), 32'd1);
      monitor_xfer(lp ? w : sw, cs_expect(dut, sel), pol,
                   pha ? 1'b0 : (dut ? w[0] : w[7]));
      if (!lp) check("slave_rx", 32'(slv_got), 32'(w));
      last_rx = lp ? w : sw;
   endtask

   initial begin
      bit         ok;
      bit         seen;
      int         tog;
      logic       prev;
      logic [7:0] rw, rs;
      logic [1:0] rsel;
      bit         rd, rl;

      reset = 1'b0; enable = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
      slave_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; which = 1'b0; loop_v = 1'b1;
      slv_word = 8'h00; last_rx = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_sclk", 32'(sclk_m), 32'd0);
      check("rst_mosi", 32'(mosi_m), 32'd0);
      check("rst_cs", 32'(cs_m), 32'h7);
      check("rst_ready", 32'(tx_ready_m), 32'd0);
      check("rst_rxv", 32'(rx_valid_m), 32'd0);
      check("rst_rxdata", 32'(rx_data_m), 32'd0);
      check("rst_busy", 32'(busy_m), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      check("ready_after_reset", 32'(tx_ready_m), 32'd1);

      // mode 0 loopback, slave 0
      xfer(1'b0, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00);
      // mode 3 with slave model
      xfer(1'b0, 8'hC3, 2'd0, 1'b1, 1'b1, 1'b0, 8'h3C);
      // LSB-first loopback
      xfer(1'b1, 8'h01, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00);
      // out-of-range select: no cs, word still returned
      xfer(1'b1, 8'hE7, 2'd3, 1'b0, 1'b0, 1'b1, 8'h00);

      // back-to-back on slave 1 with tx_valid held high
      which = 1'b0; loop_v = 1'b1; slave_sel = 2'd1; cpol = 1'b0; cpha = 1'b0;
      tx_data = 8'h11;
      repeat (2) @(negedge clk);
      tx_valid = 1'b1;
      wait_accept(ok);
      check("b2b_accept1", 32'(ok), 32'd1);
      tx_data = 8'h22;
      monitor_xfer(8'h11, 3'b101, 1'b0, 1'b0);
      wait_accept(ok);
      check("b2b_accept2", 32'(ok), 32'd1);
      check("b2b_gap", 32'(acc_cyc - rxv_cyc), 32'd2);
      tx_valid = 1'b0;
      monitor_xfer(8'h22, 3'b101, 1'b0, 1'b0);
      last_rx = 8'h22;

      // abort by enable during bit 3
      which = 1'b0; loop_v = 1'b1; slave_sel = 2'd0; cpol = 1'b0; cpha = 1'b0;
      tx_data = 8'h96;
      repeat (2) @(negedge clk);
      tx_valid = 1'b1;
      wait_accept(ok);
      tx_valid = 1'b0;
      check("abort_accept", 32'(ok), 32'd1);
      tog = 0; prev = 1'b0;
      for (int n = 0; n < 200 && tog < 6; n++) begin
         @(negedge clk);
         if (sclk_m !== prev) tog++;
         prev = sclk_m;
      end
      enable = 1'b0;
      @(negedge clk);
      check("abort_cs", 32'(cs_m), 32'h7);
      check("abort_busy", 32'(busy_m), 32'd0);
      check("abort_sclk", 32'(sclk_m), 32'd0);
      seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (rx_valid_m === 1'b1) seen = 1'b1;
      end
      check("abort_no_rxv", 32'(seen), 32'd0);
      check("abort_rx_hold", 32'(rx_data_m), 32'(last_rx));
      enable = 1'b1;
      xfer(1'b0, 8'h5A, 2'd0, 1'b0, 1'b0, 1'b1, 8'h00);

      // one-cycle reset during SHIFT
      which = 1'b0; loop_v = 1'b1; slave_sel = 2'd1; cpol = 1'b0; cpha = 1'b1;
      tx_data = 8'h3F;
      repeat (2) @(negedge clk);
      tx_valid = 1'b1;
      wait_accept(ok);
      tx_valid = 1'b0;
      tog = 0; prev = 1'b0;
      for (int n = 0; n < 200 && tog < 5; n++) begin
         @(negedge clk);
         if (sclk_m !== prev) tog++;
         prev = sclk_m;
      end
      reset = 1'b0;
      @(negedge clk);
      check("mid_rst_sclk", 32'(sclk_m), 32'd0);
      check("mid_rst_mosi", 32'(mosi_m), 32'd0);
      check("mid_rst_cs", 32'(cs_m), 32'h7);
      check("mid_rst_ready", 32'(tx_ready_m), 32'd0);
      check("mid_rst_rxv", 32'(rx_valid_m), 32'd0);
      check("mid_rst_rxdata", 32'(rx_data_m), 32'd0);
      check("mid_rst_busy", 32'(busy_m), 32'd0);
      reset = 1'b1;
      last_rx = 8'h00;
      seen = 1'b0; ok = 1'b0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rx_valid_m === 1'b1) seen = 1'b1;
         if (tx_ready_m === 1'b1) ok = 1'b1;
      end
      check("mid_rst_no_rxv", 32'(seen), 32'd0);
      check("mid_rst_ready_back", 32'(ok), 32'd1);

      // randomized transfers across both instances, modes and selects
      for (int i = 0; i < 24; i++) begin
         rd   = 1'($urandom_range(0, 1));
         rw   = 8'($urandom);
         rs   = 8'($urandom);
         rsel = rd ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 1));
         rl   = (rd && rsel == 2'd3) ? 1'b1 : 1'($urandom_range(0, 1));
         xfer(rd, rw, rsel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rl, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised SPI master: next generation of the fixed-function SPI Master in the AES-System SPI subsystem.
- Takes parallel words from the AES datapath over a valid/ready handshake and shifts them out full-duplex on SCLK/MOSI/MISO.
- Returns the received word with a one-cycle valid pulse.
- Adds what the earlier block lacks:
  - configurable word width and SCLK divider
  - runtime CPOL/CPHA mode selection
  - multiple one-hot chip selects
  - MSB/LSB-first ordering
  - clean abort via enable

Parameters:
- DATA_WIDTH, 8: bits per transfer; legal range 2 to 32.
- CLK_DIV, 2: clk cycles per SCLK half-period; minimum 1.
- NUM_SLAVES, 2: number of cs_n lines; minimum 1.
- LSB_FIRST, 0: 0 = MSB shifted first, 1 = LSB shifted first, for both MOSI and MISO.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- enable  input  1  block enable; low forces IDLE and aborts any transfer.
- tx_valid  input  1  tx_data/slave_sel/cpol/cpha are valid.
- tx_ready  output  1  master can accept a transfer.
- tx_data  input  DATA_WIDTH  word to transmit.
- slave_sel  input  clog2(NUM_SLAVES) (min 1)  target slave index.
- cpol  input  1  SCLK idle level for this transfer.
- cpha  input  1  0 = sample on leading edge, 1 = sample on trailing edge.
- rx_valid  output  1  one-cycle pulse: rx_data holds the received word.
- rx_data  output  DATA_WIDTH  last received word; held until the next rx_valid.
- busy  output  1  high from accept until return to IDLE.
- sclk  output  1  SPI clock.
- mosi  output  1  serial out.
- miso  input  1  serial in; the bench provides any synchroniser.
- cs_n  output  NUM_SLAVES  active-low chip selects; at most one low.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE; sclk=0, mosi=0, cs_n all 1.
  - tx_ready=0, rx_valid=0, rx_data=0, busy=0.
  - Abort mid-transfer is allowed; no rx_valid is issued.
- States: IDLE -> SETUP -> SHIFT -> HOLD -> IDLE.
- IDLE:
  - tx_ready = enable (registered output, 1 cycle after entry).
  - sclk tracks the registered cpol input.
- Accept when tx_valid && tx_ready:
  - Latch tx_data, slave_sel, cpol and cpha; these are ignored until the next accept.
  - Next cycle: busy=1, tx_ready=0, go to SETUP.
- SETUP (CLK_DIV cycles):
  - cs_n[slave_sel]=0.
  - CPHA=0: first data bit on mosi at entry.
  - CPHA=1: mosi=0 until the first edge.
- SHIFT: 2*DATA_WIDTH SCLK toggles, one every CLK_DIV cycles. Odd toggles are leading edges, even toggles are trailing.
  - CPHA=0: sample miso on leading edges; drive the next mosi bit on trailing edges, except the last trailing edge.
  - CPHA=1: drive mosi on leading edges; sample miso on trailing edges.
- HOLD (CLK_DIV cycles): sclk=cpol, cs_n held low.
- Leaving HOLD:
  - cs_n all 1, rx_data updated, rx_valid=1 for exactly one cycle, busy=0, enter IDLE.
- Latency: accept edge to rx_valid = (2*DATA_WIDTH+2)*CLK_DIV+1 cycles.
- Back-to-back: with tx_valid held high, the next accept occurs at the earliest 2 cycles after rx_valid. cs_n is high for at least 1 cycle between transfers.
- slave_sel >= NUM_SLAVES: the transfer runs normally with all cs_n high. rx_valid is still issued.
- enable low during SETUP/SHIFT/HOLD:
  - Next cycle: state=IDLE, cs_n all 1, sclk=cpol, busy=0.
  - No rx_valid; rx_data unchanged.
- tx_valid while busy: ignored, with no side effects.
- Bit counter width: clog2(DATA_WIDTH)+1. Divider counter width: clog2(CLK_DIV)+1. No wrap beyond terminal counts.

Test Plan:
- Loopback, DATA_WIDTH=8, CLK_DIV=2, mode 0, sel 0, tx 0xA5:
  - rx_data=0xA5 with rx_valid at accept+37 cycles.
  - cs_n=2'b10 during transfer; 16 sclk toggles, idle 0.
- Mode 3, slave model returns 0x3C, tx 0xC3:
  - Slave captures 0xC3; rx_data=0x3C; sclk idles 1 before and after.
- LSB_FIRST=1, loopback, tx 0x01:
  - First mosi bit is 1; rx_data=0x01.
- sel=1, two back-to-back transfers (0x11, 0x22), tx_valid held high:
  - cs_n=2'b01 for each; cs_n=2'b11 for >=1 cycle between them.
  - Two rx_valid pulses with rx_data 0x11 then 0x22.
- Abort: enable dropped at SHIFT bit 3, re-enabled later:
  - cs_n=2'b11 next cycle, no rx_valid, rx_data unchanged.
  - Next transfer 0x5A completes correctly.
- reset=0 for one cycle mid-SHIFT:
  - All outputs at reset values next cycle; no rx_valid; tx_ready returns after reset releases.
